// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and defaults for uart_tx_arbiter
//   arb_state_t        : arbiter FSM states
//   DEF_TIMEOUT_CYCLES : default watchdog limit (0.1 s at 50 MHz)
package uart_tx_arb_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, BUSY, DRAIN} arb_state_t;
    localparam int DEF_TIMEOUT_CYCLES = 5000000;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: source-side and UART-side handshake bundle of uart_tx_arbiter
//   req/byte_valid/byte_last/byte_data : per-source request and byte stream
//   gnt/byte_ack                       : per-source grant and byte accept pulse
//   tx_data/tx_start/tx_active         : UART transmitter handshake
//   master: the arbiter, slave: sources plus UART
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   byte_valid;
    logic [N_REQ-1:0]   byte_last;
    logic [8*N_REQ-1:0] byte_data;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   byte_ack;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_active;

    modport master (
        input  req, byte_valid, byte_last, byte_data, tx_active,
        output gnt, byte_ack, tx_data, tx_start
    );

    modport slave (
        output req, byte_valid, byte_last, byte_data, tx_active,
        input  gnt, byte_ack, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req : request vector
//   ptr : index with highest priority
//   win : one-hot winner, zero when nothing requests
//   idx : index of the winner
//   any : at least one request pending
module rr_pick #(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;

    // scan from the farthest offset back toward ptr so the nearest request wins
    always_comb begin
        win = '0;
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                win = N'(1) << j;
                idx = j;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-atomic sharing of one UART transmitter
//   clk_50mhz   : the only clock
//   reset       : synchronous, active-high
//   bus         : master side of uart_tx_arbiter_if (sources in, grants/acks out, UART handshake)
//   busy        : FSM outside IDLE
//   timeout_evt : one-cycle pulse when the watchdog forces a release
//   UART_TX_ARB_TIMEOUT_EN enables the watchdog and its TIMEOUT_CYCLES parameter.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic               clk_50mhz,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus,
    output logic               busy,
    output logic               timeout_evt
);
    localparam int W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [W-1:0]     own_q, own_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             last_q, last_d;
    logic [N_REQ-1:0] win;
    logic [W-1:0]     win_idx;
    logic             any_req;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tevt_q, tevt_d;
`endif

    rr_pick #(.N(N_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win),
        .idx (win_idx),
        .any (any_req)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_d      = own_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        last_d     = last_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = GRANT;
                gnt_d   = win;
                own_d   = win_idx;
                ptr_d   = (win_idx == W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            GRANT: if (!bus.req[own_q]) begin
                state_d = IDLE;
                gnt_d   = '0;
            end else if (bus.byte_valid[own_q]) begin
                state_d   = LAUNCH;
                ack_d     = gnt_q;
                tx_data_d = bus.byte_data[8*own_q +: 8];
                last_d    = bus.byte_last[own_q];
            end
            LAUNCH: begin
                state_d    = BUSY;
                tx_start_d = 1'b1;
            end
            BUSY: if (bus.tx_active) state_d = DRAIN;
            DRAIN: if (!bus.tx_active) begin
                state_d = last_q ? IDLE : GRANT;
                gnt_d   = last_q ? '0 : gnt_q;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        tevt_d = 1'b0;
        cnt_d  = '0;
        // the counter restarts on every state change, so it measures time spent in one wait
        if (state_q == GRANT || state_q == BUSY) begin
            if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                state_d   = IDLE;
                gnt_d     = '0;
                ack_d     = '0;
                tx_data_d = tx_data_q;
                last_d    = last_q;
                tevt_d    = 1'b1;
            end else if (state_d == state_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            own_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tevt_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            last_q     <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tevt_q     <= tevt_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.byte_ack = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_evt  = tevt_q;
`else
    assign timeout_evt  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed timing checks plus randomized packet streams against a packet-level model
module tb_uart_tx_arbiter;
    localparam int N = 2;

    logic clk_50mhz = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic timeout_evt;

    int n_chk = 0;
    int n_pass = 0;
    int uart_len = 10;
    bit uart_dead = 1'b0;
    int u_t = 0;

    logic [8:0]  src_q [N][$];
    logic [8:0]  mq    [N][$];
    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    int ack_cnt [N];
    int nby [N];

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N)
`ifdef UART_TX_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(20)
`endif
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // UART model: tx_active rises 2 cycles after tx_start and stays high uart_len cycles
    always @(posedge clk_50mhz) begin
        if (bus.tx_start && !uart_dead) u_t <= 1;
        else if (u_t != 0) u_t <= (u_t > uart_len) ? 0 : u_t + 1;
    end
    assign bus.tx_active = (u_t >= 2) && (u_t <= uart_len + 1);

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] own_of(input logic [N-1:0] g);
        own_of = 8'hFF;
        for (int i = 0; i < N; i++) if (g[i]) own_of = 8'(i);
    endfunction

    task automatic tick();
        @(negedge clk_50mhz);
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
        check("ack_to_owner", 32'(bus.byte_ack & ~bus.gnt), 0);
        if (bus.tx_start) obs_q.push_back({own_of(bus.gnt), bus.tx_data});
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(bus.byte_ack[i]);
    endtask

    task automatic clear_inputs();
        bus.req        = '0;
        bus.byte_valid = '0;
        bus.byte_last  = '0;
        bus.byte_data  = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 0);
        check({tag, "_ack"}, 32'(bus.byte_ack), 0);
        check({tag, "_start"}, 32'(bus.tx_start), 0);
        check({tag, "_data"}, 32'(bus.tx_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_tevt"}, 32'(timeout_evt), 0);
    endtask

    task automatic do_reset();
        int c;
        reset = 1'b1;
        clear_inputs();
        c = 0;
        while (u_t != 0 && c < 100) begin
            tick();
            c++;
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_act(input logic v, input string tag);
        int c;
        c = 0;
        while (bus.tx_active !== v && c < 200) begin
            tick();
            c++;
        end
        check(tag, 32'(bus.tx_active), 32'(v));
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input bit last);
        src_q[i].push_back({last, d});
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (bus.byte_ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            bus.req[i] = (src_q[i].size() != 0);
            if (bus.gnt[i] && src_q[i].size() != 0) begin
                bus.byte_valid[i]       = ($urandom_range(3) != 0);
                bus.byte_data[8*i +: 8] = src_q[i][0][7:0];
                bus.byte_last[i]        = src_q[i][0][8];
            end else begin
                bus.byte_valid[i]       = 1'($urandom);
                bus.byte_data[8*i +: 8] = 8'($urandom);
                bus.byte_last[i]        = 1'($urandom);
            end
        end
    endtask

    function automatic int pending();
        pending = 0;
        for (int i = 0; i < N; i++) pending += src_q[i].size();
    endfunction

    // Packet-level reference: whole packets in round-robin order over non-empty sources
    task automatic run_auto(input string tag);
        int ptr, w, cyc;
        logic [8:0] b;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < N; i++) begin
            mq[i]      = src_q[i];
            nby[i]     = src_q[i].size();
            ack_cnt[i] = 0;
        end
        ptr = 0;
        forever begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(ptr + k) % N].size() != 0) w = (ptr + k) % N;
            if (w < 0) break;
            do begin
                b = mq[w].pop_front();
                exp_q.push_back({8'(w), b[7:0]});
            end while (!b[8]);
            ptr = (w + 1) % N;
        end
        drive_src();
        cyc = 0;
        while ((pending() != 0 || bus.gnt != '0) && cyc < 5000) begin
            tick();
            drive_src();
            cyc++;
        end
        clear_inputs();
        check({tag, "_done"}, 32'(cyc < 5000), 1);
        check({tag, "_tx_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
            check({tag, "_tx_seq"}, 32'(obs_q[k]), 32'(exp_q[k]));
        for (int i = 0; i < N; i++) check({tag, "_ack_count"}, 32'(ack_cnt[i]), 32'(nby[i]));
    endtask

    task automatic gen_random();
        int np, nb;
        uart_len = $urandom_range(12, 1);
        for (int i = 0; i < N; i++) begin
            np = $urandom_range(3, 0);
            for (int p = 0; p < np; p++) begin
                nb = $urandom_range(4, 1);
                for (int q = 0; q < nb; q++) add_byte(i, 8'($urandom), q == nb - 1);
            end
        end
    endtask

    initial begin
        int n_obs, n_ack;
        clear_inputs();
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check("idle_gnt", 32'(bus.gnt), 0);

        // request-to-grant and byte-to-launch latency, then hand-over to the other source
        bus.req = 2'b01;
        tick();
        check("gnt_latency", 32'(bus.gnt), 32'h1);
        check("busy_granted", 32'(busy), 1);
        bus.req[1]           = 1'b1;
        bus.byte_valid[0]    = 1'b1;
        bus.byte_data[7:0]   = 8'hA5;
        bus.byte_last[0]     = 1'b1;
        tick();
        check("ack_latency", 32'(bus.byte_ack), 32'h1);
        check("tx_data_latch", 32'(bus.tx_data), 32'hA5);
        check("no_early_start", 32'(bus.tx_start), 0);
        bus.byte_valid = '0;
        tick();
        check("start_latency", 32'(bus.tx_start), 1);
        check("ack_single", 32'(bus.byte_ack), 0);
        bus.req[0] = 1'b0;
        tick();
        check("start_one_cycle", 32'(bus.tx_start), 0);
        wait_act(1'b1, "uart_rise");
        wait_act(1'b0, "uart_fall");
        check("gnt_held_drain", 32'(bus.gnt), 32'h1);
        tick();
        check("gnt_release", 32'(bus.gnt), 0);
        tick();
        check("gnt_handover", 32'(bus.gnt), 32'h2);

        // abort between bytes: requester 1 drops req after its first byte
        bus.byte_valid[1]   = 1'b1;
        bus.byte_data[15:8] = 8'h5A;
        bus.byte_last[1]    = 1'b0;
        tick();
        check("abort_ack1", 32'(bus.byte_ack), 32'h2);
        bus.byte_valid = '0;
        wait_act(1'b1, "abort_rise");
        wait_act(1'b0, "abort_fall");
        tick();
        check("abort_regrant", 32'(bus.gnt), 32'h2);
        bus.req[1]        = 1'b0;
        bus.byte_valid[1] = 1'b1;
        n_obs = obs_q.size();
        n_ack = ack_cnt[1];
        tick();
        check("abort_gnt", 32'(bus.gnt), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (6) tick();
        check("abort_no_start", 32'(obs_q.size()), 32'(n_obs));
        check("abort_no_ack", 32'(ack_cnt[1]), 32'(n_ack));
        bus.byte_valid = '0;

        // dropping req after the ack still completes the byte
        bus.req = 2'b01;
        tick();
        check("drop_gnt", 32'(bus.gnt), 32'h1);
        bus.byte_valid[0]  = 1'b1;
        bus.byte_data[7:0] = 8'h77;
        bus.byte_last[0]   = 1'b0;
        tick();
        bus.byte_valid = '0;
        bus.req        = '0;
        tick();
        check("drop_start", 32'(bus.tx_start), 1);
        check("drop_data", 32'(bus.tx_data), 32'h77);
        wait_act(1'b1, "drop_rise");
        wait_act(1'b0, "drop_fall");
        tick();
        tick();
        check("drop_release", 32'(bus.gnt), 0);

        // stalled UART: watchdog release or indefinite wait in BUSY
        do_reset();
        uart_dead = 1'b1;
        bus.req = 2'b11;
        tick();
        check("stall_gnt", 32'(bus.gnt), 32'h1);
        bus.byte_valid[0]  = 1'b1;
        bus.byte_data[7:0] = 8'h3C;
        bus.byte_last[0]   = 1'b1;
        tick();
        bus.byte_valid = '0;
        tick();
        check("stall_start", 32'(bus.tx_start), 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        repeat (19) begin
            tick();
            check("no_early_timeout", 32'(timeout_evt), 0);
        end
        tick();
        check("timeout_evt", 32'(timeout_evt), 1);
        check("timeout_gnt", 32'(bus.gnt), 0);
        tick();
        check("timeout_pulse", 32'(timeout_evt), 0);
        check("timeout_next", 32'(bus.gnt), 32'h2);
`else
        repeat (30) tick();
        check("stall_hold_gnt", 32'(bus.gnt), 32'h1);
        check("stall_busy", 32'(busy), 1);
        check("stall_no_tevt", 32'(timeout_evt), 0);
`endif
        uart_dead = 1'b0;
        do_reset();

        // reset while draining: outputs clear and the pointer restarts at requester 0
        uart_len = 10;
        bus.req = 2'b11;
        tick();
        bus.byte_valid[0]  = 1'b1;
        bus.byte_data[7:0] = 8'h99;
        bus.byte_last[0]   = 1'b0;
        tick();
        bus.byte_valid = '0;
        wait_act(1'b1, "rst_rise");
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        tick();
        check("rr_restart", 32'(bus.gnt), 32'h1);
        do_reset();

        uart_len = 10;
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        run_auto("single");

        do_reset();
        add_byte(0, 8'hA1, 1'b0);
        add_byte(0, 8'hA2, 1'b0);
        add_byte(0, 8'hA3, 1'b1);
        add_byte(1, 8'hB1, 1'b0);
        add_byte(1, 8'hB2, 1'b1);
        run_auto("contention");

        do_reset();
        uart_len = 3;
        for (int p = 0; p < 4; p++) begin
            add_byte(0, 8'(8'h40 + p), 1'b1);
            add_byte(1, 8'(8'h80 + p), 1'b1);
        end
        run_auto("fairness");

        for (int r = 0; r < 6; r++) begin
            do_reset();
            gen_random();
            run_auto("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (8-bit `tx_data`, `tx_start`, `tx_active` handshake) between up to `N_REQ` byte-stream sources, e.g. the sample readout path and the command/status responder. Grants are round-robin and held for a whole packet, so packets from different sources never interleave on the serial line. The block sits between the source modules and the UART TX core and owns `tx_start` exclusively.

## Interface
- `N_REQ`, 2: number of requesters, legal range 2–8.
- `TIMEOUT_CYCLES`, 5000000: watchdog limit in `clk_50mhz` cycles (0.1 s); used only with the timeout feature.
- `clk_50mhz` input 1: the only clock.
- `reset` input 1: synchronous, active-high.
- `req` input N_REQ: requester i wants the line for one packet.
- `byte_valid` input N_REQ: owner presents a byte.
- `byte_last` input N_REQ: the presented byte ends the packet.
- `byte_data` input 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `gnt` output N_REQ: one-hot grant, registered.
- `byte_ack` output N_REQ: one-cycle pulse, byte of requester i accepted.
- `tx_data` output 8: byte to the UART, held stable from launch until the transmitter goes idle again.
- `tx_start` output 1: one-cycle launch pulse to the UART.
- `tx_active` input 1: UART busy transmitting.
- `busy` output 1: high in any state other than IDLE.
- `timeout_evt` output 1: one-cycle pulse when the watchdog forces a release; tied to 0 without the macro.

## Operation
- All outputs reset to 0. The round-robin pointer resets to 0 and the FSM resets to IDLE.
- **IDLE**
  - Selects the first asserted `req` at or after the pointer, wrapping modulo N_REQ.
  - Sets `gnt[i]` and goes to GRANT.
  - Sets the pointer to (i+1) mod N_REQ.
- **GRANT**
  - If `req[i]`=0, clears `gnt` and returns to IDLE (abort between bytes).
  - Else if `byte_valid[i]`, pulses `byte_ack[i]`, latches `byte_data[i]` into `tx_data`, latches `byte_last[i]`, and goes to LAUNCH.
- **LAUNCH**: `tx_start`=1 for exactly this cycle, then BUSY.
- **BUSY**: waits for `tx_active`=1, then DRAIN.
- **DRAIN**
  - Waits for `tx_active`=0.
  - If the latched last flag is set, clears `gnt` and goes to IDLE; otherwise returns to GRANT.
- Ignored inputs:
  - `byte_valid`, `byte_last` and `byte_data` of non-owners are ignored.
  - `req` of the owner is ignored from LAUNCH through DRAIN; a byte in flight always completes.
- `gnt` is one-hot or zero at all times.
- `byte_ack` goes only to the owner, at most once per byte.
- When `reset` is asserted mid-packet, everything returns to the reset state on the next edge. A UART transfer already in progress is not cancelled.

## Timing
- `req` rises in cycle t while IDLE: `gnt` high at t+1.
- `byte_valid` high in GRANT at cycle t: `byte_ack` and `tx_data` valid at t+1, `tx_start` at t+2.
- After `tx_active` falls in DRAIN, the next byte of the same packet can be acked 2 cycles later (DRAIN→GRANT, then accept).
- After a last byte, a different requester's `gnt` is high 2 cycles after `tx_active` falls (DRAIN→IDLE→grant).
- A requester holding `req` for the next packet regains the line only after every other pending requester has had one packet.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter sized $clog2(TIMEOUT_CYCLES+1) clears on every state change and counts in GRANT and BUSY.
  - On reaching TIMEOUT_CYCLES it clears `gnt`, pulses `timeout_evt` and returns to IDLE.
  - A stalled owner or a missing `tx_active` rise therefore cannot lock the line.
- Macro undefined: no counter; GRANT and BUSY wait indefinitely; `timeout_evt` is constant 0.

## Structure
- Package `uart_tx_arb_pkg`: state enum `arb_state_t` (IDLE, GRANT, LAUNCH, BUSY, DRAIN) and the default TIMEOUT_CYCLES constant.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and pointer.
  - Outputs: one-hot winner, winner index, and an any-request flag.

## Test plan
- **Single source:** N_REQ=2, `req[0]` with 3 bytes 0x11, 0x22, 0x33 (last on 0x33); UART model raises `tx_active` 2 cycles after `tx_start` for 10 cycles.
  - Expect 3 `tx_start` pulses carrying 0x11, 0x22, 0x33, 3 `byte_ack[0]` pulses, then `gnt`=0.
- **Contention:** `req[0]` and `req[1]` asserted in the same cycle from reset.
  - Expect requester 0 granted first and its full packet sent, then `gnt[1]`.
  - No byte of requester 1 appears between bytes of requester 0.
- **Fairness:** both requesters assert `req` continuously with 1-byte packets.
  - Expect grants to alternate 0, 1, 0, 1 over 8 packets.
- **Abort:** `req[1]` dropped in GRANT after 1 of 4 bytes.
  - Expect release to IDLE the next cycle, no further `tx_start`, and no `byte_ack`.
  - Dropping `req` during BUSY must still complete that byte.
- **Timeout (macro on, TIMEOUT_CYCLES=20):** UART model never raises `tx_active`.
  - Expect `timeout_evt` pulse 20 cycles after BUSY entry, `gnt`=0, and the other requester served next.
  - With the macro off, the same stimulus leaves the FSM in BUSY.
- **Reset mid-packet:** assert `reset` in DRAIN.
  - Expect all outputs 0 and state IDLE after the edge.
  - The next grant starts from requester 0.
